// File: rtl/e_unary_stream_dec_if.sv
// Valid/ready stream bundle for the unary decoder: input beat, output beat, downstream ready.
// The DUT uses the slave modport and the traffic source/sink uses the master modport.
interface e_unary_stream_dec_if #(
  parameter int W = 8
);
  localparam int CNT_W = $clog2(W);

  logic             i_vld;
  logic [W-1:0]     i_x;
  logic             o_rdy;
  logic             o_vld;
  logic [CNT_W-1:0] o_cnt;
  logic             o_is_compliment;
  logic             o_err;
  logic             i_rdy;

  modport slave (
    input  i_vld, i_x, i_rdy,
    output o_rdy, o_vld, o_cnt, o_is_compliment, o_err
  );

  modport master (
    output i_vld, i_x, i_rdy,
    input  o_rdy, o_vld, o_cnt, o_is_compliment, o_err
  );
endinterface

// File: rtl/e_unary_stream_dec.sv
// Two-stage elastic decoder for unary/thermometer beats.
// S1 classifies each beat, and S2 registers the count, complement flag and error flag.
module e_unary_stream_dec #(
  parameter int W                     = 8,
  parameter int P_ADMIT_COMPLIMENT_EN = 1,
  parameter int P_DROP_ERR_EN         = 0,
  parameter int P_ERR_CNT_W           = 16
) (
  input  logic                      clk,
  input  logic                      arst_n,
  e_unary_stream_dec_if.slave       strm,
  output logic [P_ERR_CNT_W-1:0]    o_err_cnt
);
  localparam int               CNT_W = $clog2(W);
  localparam logic             CEN   = (P_ADMIT_COMPLIMENT_EN != 0);
  localparam logic             DROP  = (P_DROP_ERR_EN != 0);
  localparam logic [CNT_W:0]   W_L   = (CNT_W + 1)'(W);

  logic [W-2:0]       edges;
  logic               x_uni;
  logic               x_cmp;
  logic               accept;
  logic               s1_adv;
  logic               s2_adv;

  logic               s1_vld;
  logic [W-1:0]       s1_x;
  logic               s1_uni;
  logic               s1_cmp;

  logic               s2_vld;
  logic [CNT_W-1:0]   s2_cnt;
  logic               s2_cmp;
  logic               s2_err;

  logic [CNT_W:0]     pop;
  logic [CNT_W-1:0]   cnt_d;
  logic [P_ERR_CNT_W-1:0] err_cnt;

  assign edges  = strm.i_x[W-1:1] ^ strm.i_x[W-2:0];
  assign x_uni  = ($onehot(edges) & (strm.i_x[0] | (CEN & strm.i_x[W-1])))
                | (strm.i_x == '0)
                | (CEN & (strm.i_x == '1));
  assign x_cmp  = CEN & strm.i_x[W-1] & x_uni;

  assign s2_adv = !s2_vld | strm.i_rdy;
  assign s1_adv = !s1_vld | s2_adv;
  assign accept = strm.i_vld & s1_adv;

  // A dropped beat still consumes the S1 slot this cycle, so S1 simply loads a bubble.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s1_vld <= 1'b0;
      s1_x   <= '0;
      s1_uni <= 1'b0;
      s1_cmp <= 1'b0;
    end else if (s1_adv) begin
      s1_vld <= accept & (x_uni | !DROP);
      s1_x   <= strm.i_x;
      s1_uni <= x_uni;
      s1_cmp <= x_cmp;
    end
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < W; i++) begin
      pop = pop + (CNT_W + 1)'(s1_x[i]);
    end
    cnt_d = '0;
    if (s1_uni) begin
      cnt_d = s1_cmp ? CNT_W'(W_L - pop) : CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s2_vld <= 1'b0;
      s2_cnt <= '0;
      s2_cmp <= 1'b0;
      s2_err <= 1'b0;
    end else if (s2_adv) begin
      s2_vld <= s1_vld;
      s2_cnt <= cnt_d;
      s2_cmp <= s1_cmp;
      s2_err <= !s1_uni;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      err_cnt <= '0;
    end else if (accept && !x_uni && (err_cnt != '1)) begin
      err_cnt <= err_cnt + P_ERR_CNT_W'(1);
    end
  end

  assign strm.o_rdy           = s1_adv;
  assign strm.o_vld           = s2_vld;
  assign strm.o_cnt           = s2_cnt;
  assign strm.o_is_compliment = s2_cmp;
  assign strm.o_err           = s2_err;
  assign o_err_cnt            = err_cnt;
endmodule

// File: tb/tb_e_unary_stream_dec.sv
// Directed bench for e_unary_stream_dec using three configurations driven by a shared stimulus:
// A (complement on, forward errors), B (complement off, 2-bit error count) and C (complement on, drop errors).
module tb_e_unary_stream_dec;
  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       vld = 1'b0;
  logic [7:0] xin = '0;
  logic       rdy = 1'b1;
  logic [15:0] err_cnt_a;
  logic [1:0]  err_cnt_b;
  logic [15:0] err_cnt_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  e_unary_stream_dec_if #(.W(8)) ifa ();
  e_unary_stream_dec_if #(.W(8)) ifb ();
  e_unary_stream_dec_if #(.W(8)) ifc ();

  assign ifa.i_vld = vld;
  assign ifa.i_x   = xin;
  assign ifa.i_rdy = rdy;
  assign ifb.i_vld = vld;
  assign ifb.i_x   = xin;
  assign ifb.i_rdy = rdy;
  assign ifc.i_vld = vld;
  assign ifc.i_x   = xin;
  assign ifc.i_rdy = rdy;

  e_unary_stream_dec #(.W(8), .P_ADMIT_COMPLIMENT_EN(1), .P_DROP_ERR_EN(0), .P_ERR_CNT_W(16)) dut_a (
    .clk(clk), .arst_n(arst_n), .strm(ifa), .o_err_cnt(err_cnt_a));
  e_unary_stream_dec #(.W(8), .P_ADMIT_COMPLIMENT_EN(0), .P_DROP_ERR_EN(0), .P_ERR_CNT_W(2)) dut_b (
    .clk(clk), .arst_n(arst_n), .strm(ifb), .o_err_cnt(err_cnt_b));
  e_unary_stream_dec #(.W(8), .P_ADMIT_COMPLIMENT_EN(1), .P_DROP_ERR_EN(1), .P_ERR_CNT_W(16)) dut_c (
    .clk(clk), .arst_n(arst_n), .strm(ifc), .o_err_cnt(err_cnt_c));

  typedef struct {
    logic [7:0] x;
    int a_cnt, a_cmp, a_err;
    int b_cnt, b_cmp, b_err;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Present one beat for a single cycle and return at the sample point of its output cycle.
  task automatic run_beat(input logic [7:0] x);
    @(negedge clk);
    vld = 1'b1;
    xin = x;
    @(negedge clk);
    vld = 1'b0;
    #1;
    check("lat_a_not_early", int'(ifa.o_vld), 0);
    @(negedge clk);
    #1;
  endtask

  int idx;
  int nout;
  int out_cnt[6];
  int out_cyc[6];
  int exp_cyc[6];

  initial begin
    tbl[0] = '{8'b0000_0111, 3, 0, 0, 3, 0, 0};
    tbl[1] = '{8'b0000_0000, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{8'b1111_1000, 3, 1, 0, 0, 0, 1};
    tbl[3] = '{8'b1111_1111, 0, 1, 0, 0, 0, 1};
    tbl[4] = '{8'b0101_0000, 0, 0, 1, 0, 0, 1};
    tbl[5] = '{8'b0000_0001, 1, 0, 0, 1, 0, 0};
    tbl[6] = '{8'b0111_1111, 7, 0, 0, 7, 0, 0};
    tbl[7] = '{8'b1000_0000, 7, 1, 0, 0, 0, 1};
    tbl[8] = '{8'b1000_0001, 0, 0, 1, 0, 0, 1};
    exp_cyc = '{2, 6, 7, 8, 9, 10};

    #1;
    check("rst_o_vld", int'(ifa.o_vld), 0);
    check("rst_o_rdy", int'(ifa.o_rdy), 1);
    check("rst_o_cnt", int'(ifa.o_cnt), 0);
    check("rst_o_err", int'(ifa.o_err), 0);
    check("rst_o_cmp", int'(ifa.o_is_compliment), 0);
    check("rst_err_cnt", int'(err_cnt_a), 0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_beat(tbl[i].x);
      check($sformatf("tbl%0d_a_vld", i), int'(ifa.o_vld), 1);
      check($sformatf("tbl%0d_a_cnt", i), int'(ifa.o_cnt), tbl[i].a_cnt);
      check($sformatf("tbl%0d_a_cmp", i), int'(ifa.o_is_compliment), tbl[i].a_cmp);
      check($sformatf("tbl%0d_a_err", i), int'(ifa.o_err), tbl[i].a_err);
      check($sformatf("tbl%0d_b_vld", i), int'(ifb.o_vld), 1);
      check($sformatf("tbl%0d_b_cnt", i), int'(ifb.o_cnt), tbl[i].b_cnt);
      check($sformatf("tbl%0d_b_cmp", i), int'(ifb.o_is_compliment), tbl[i].b_cmp);
      check($sformatf("tbl%0d_b_err", i), int'(ifb.o_err), tbl[i].b_err);
    end
    check("tbl_err_cnt_a", int'(err_cnt_a), 2);
    check("tbl_err_cnt_b_sat", int'(err_cnt_b), 3);
    check("tbl_err_cnt_c", int'(err_cnt_c), 2);

    // Six beats with counts 1..6 while downstream stalls for cycles 3..5.
    @(negedge clk);
    idx = 0;
    nout = 0;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      rdy = !(c >= 3 && c <= 5);
      if (idx < 6) begin
        vld = 1'b1;
        xin = 8'((1 << (idx + 1)) - 1);
      end else begin
        vld = 1'b0;
      end
      #1;
      check($sformatf("bp_o_rdy_c%0d", c), int'(ifa.o_rdy), (c >= 3 && c <= 5) ? 0 : 1);
      if (ifa.o_vld && rdy && nout < 6) begin
        out_cnt[nout] = int'(ifa.o_cnt);
        out_cyc[nout] = c;
        nout++;
      end
      if (vld && ifa.o_rdy) idx++;
    end
    vld = 1'b0;
    rdy = 1'b1;
    check("bp_n_out", nout, 6);
    for (int k = 0; k < 6; k++) begin
      if (k < nout) begin
        check($sformatf("bp_out%0d_cnt", k), out_cnt[k], k + 1);
        check($sformatf("bp_out%0d_cyc", k), out_cyc[k], exp_cyc[k]);
      end
    end

    // Park two beats in the pipeline, then reset asynchronously in the middle of a cycle.
    @(negedge clk);
    rdy = 1'b0;
    vld = 1'b1;
    xin = 8'h03;
    @(negedge clk);
    xin = 8'h07;
    @(negedge clk);
    vld = 1'b0;
    #1;
    check("full_o_vld", int'(ifa.o_vld), 1);
    check("full_o_rdy", int'(ifa.o_rdy), 0);
    check("full_o_cnt", int'(ifa.o_cnt), 2);
    #2;
    arst_n = 1'b0;
    #1;
    check("mrst_o_vld", int'(ifa.o_vld), 0);
    check("mrst_o_rdy", int'(ifa.o_rdy), 1);
    check("mrst_o_cnt", int'(ifa.o_cnt), 0);
    check("mrst_err_cnt_a", int'(err_cnt_a), 0);
    check("mrst_err_cnt_b", int'(err_cnt_b), 0);
    @(negedge clk);
    arst_n = 1'b1;
    rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("mrst_no_stale%0d", k), int'(ifa.o_vld), 0);
    end
    run_beat(8'h03);
    check("post_rst_vld", int'(ifa.o_vld), 1);
    check("post_rst_cnt", int'(ifa.o_cnt), 2);

    // The drop configuration counts a non-unary beat but emits nothing for it.
    run_beat(8'b0101_0000);
    check("drop_c_vld", int'(ifc.o_vld), 0);
    check("drop_c_rdy", int'(ifc.o_rdy), 1);
    check("drop_c_err_cnt", int'(err_cnt_c), 1);
    check("fwd_a_vld", int'(ifa.o_vld), 1);
    check("fwd_a_err", int'(ifa.o_err), 1);
    check("fwd_a_cnt", int'(ifa.o_cnt), 0);
    check("fwd_a_err_cnt", int'(err_cnt_a), 1);
    @(negedge clk);
    #1;
    check("drop_c_vld_late", int'(ifc.o_vld), 0);
    run_beat(8'h03);
    check("drop_c_next_vld", int'(ifc.o_vld), 1);
    check("drop_c_next_cnt", int'(ifc.o_cnt), 2);
    check("drop_c_next_err", int'(ifc.o_err), 0);

    // Five back-to-back non-unary beats on top of the one already counted.
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      vld = 1'b1;
      xin = 8'b0101_0000;
      @(posedge clk);
      #1;
      check($sformatf("sat_b_k%0d", k), int'(err_cnt_b), (1 + k > 3) ? 3 : 1 + k);
      check($sformatf("sat_c_k%0d", k), int'(err_cnt_c), 1 + k);
    end
    @(negedge clk);
    vld = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("sat_b_hold", int'(err_cnt_b), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
